// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/shift/add ops, iterative shift-add multiply
// and restoring divide, registered result and flags behind valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for an op, in_ready=1
// BUSY  | iterating MUL/MULHU/DIVU/REMU, one bit per cycle
// DONE  | result and flags presented, waiting for out_ready
module alu_mc #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             ovf_flag,
  output logic             illegal_op
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] b_q, hi_q, lo_q;
  logic [CW-1:0]    cnt_q;

  logic             accept, iter_op, is_mul;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum_w, dif_w;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry, sc_ovf, sc_ill;
  logic [WIDTH:0]   mul_sum, div_sh, div_dif;
  logic [WIDTH-1:0] hi_step, lo_step, it_res;
  logic             load, carry_nxt, ovf_nxt, ill_nxt;
  logic [WIDTH-1:0] res_nxt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign iter_op   = (alu_ctrl >= 4'd9) && (alu_ctrl <= 4'd12);
  assign is_mul    = (op_q == 4'b1001) || (op_q == 4'b1010);

  always_comb begin
    shamt    = in2[SHW-1:0];
    sum_w    = {1'b0, in1} + {1'b0, in2};
    dif_w    = {1'b0, in1} - {1'b0, in2};
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_ill   = 1'b0;
    case (alu_ctrl)
      4'b0000: sc_res = in1 & in2;
      4'b0001: sc_res = in1 | in2;
      4'b0010: begin
        sc_res   = sum_w[WIDTH-1:0];
        sc_carry = sum_w[WIDTH];
        sc_ovf   = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum_w[WIDTH-1] != in1[WIDTH-1]);
      end
      4'b0011: sc_res = in1 ^ in2;
      4'b0100: sc_res = in1 << shamt;
      4'b0101: sc_res = in1 >> shamt;
      4'b0110: begin
        sc_res   = dif_w[WIDTH-1:0];
        sc_carry = dif_w[WIDTH];
        sc_ovf   = (in1[WIDTH-1] != in2[WIDTH-1]) && (dif_w[WIDTH-1] != in1[WIDTH-1]);
      end
      4'b0111: sc_res = {{(WIDTH-1){1'b0}}, dif_w[WIDTH]};
      4'b1000: sc_res = $signed(in1) >>> shamt;
      4'b1001, 4'b1010, 4'b1011, 4'b1100: sc_res = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  // hi/lo hold the partial product (mul) or partial remainder/quotient (div)
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh  = {hi_q, lo_q[WIDTH-1]};
    div_dif = div_sh - {1'b0, b_q};
    if (is_mul) begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else if (!div_dif[WIDTH]) begin
      hi_step = div_dif[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_step = div_sh[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], 1'b0};
    end
    it_res = ((op_q == 4'b1001) || (op_q == 4'b1011)) ? lo_step : hi_step;
  end

  always_comb begin
    load      = 1'b0;
    res_nxt   = sc_res;
    carry_nxt = sc_carry;
    ovf_nxt   = sc_ovf;
    ill_nxt   = sc_ill;
    if (accept && !iter_op) begin
      load = 1'b1;
    end else if (state == BUSY && cnt_q == '0) begin
      load      = 1'b1;
      res_nxt   = it_res;
      carry_nxt = 1'b0;
      ovf_nxt   = 1'b0;
      ill_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = iter_op ? BUSY : DONE;
      BUSY:    if (cnt_q == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      op_q  <= alu_ctrl;
      b_q   <= in2;
      hi_q  <= '0;
      lo_q  <= in1;
      cnt_q <= CW'(WIDTH - 1);
    end else if (state == BUSY) begin
      hi_q <= hi_step;
      lo_q <= lo_step;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      ovf_flag   <= 1'b0;
      illegal_op <= 1'b0;
    end else if (load) begin
      alu_result <= res_nxt;
      zero_flag  <= (res_nxt == '0);
      carry_flag <= carry_nxt;
      ovf_flag   <= ovf_nxt;
      illegal_op <= ill_nxt;
    end
  end

endmodule
